// File: rtl/dec_stage.sv
// RV32I decode stage: combinational decode captured into an output register backed by a
// one-entry skid buffer, so fetch sees a purely registered ready and full throughput is kept.
module dec_stage #(
    parameter int XLEN     = 32,
    parameter int REG_BITS = 5
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_inst,
    input  logic [XLEN-1:0]     in_pc,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     out_pc,
    output logic [REG_BITS-1:0] rd,
    output logic [REG_BITS-1:0] rs1,
    output logic [REG_BITS-1:0] rs2,
    output logic [XLEN-1:0]     imm,
    output logic [3:0]          alu_op,
    output logic [3:0]          inst_type,
    output logic [3:0]          mem_wbmask,
    output logic                is_mem_sign,
    output logic                ebreak,
    output logic                illegal,
    output logic                halted
);

    localparam logic [3:0] T_IMM    = 4'd0;
    localparam logic [3:0] T_REG    = 4'd1;
    localparam logic [3:0] T_LOAD   = 4'd2;
    localparam logic [3:0] T_STORE  = 4'd3;
    localparam logic [3:0] T_LUI    = 4'd4;
    localparam logic [3:0] T_AUIPC  = 4'd5;
    localparam logic [3:0] T_JAL    = 4'd6;
    localparam logic [3:0] T_JALR   = 4'd7;
    localparam logic [3:0] T_BRANCH = 4'd8;
    localparam logic [3:0] T_SYS    = 4'd9;
    localparam logic [3:0] T_ILL    = 4'd15;

    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

    typedef struct packed {
        logic [XLEN-1:0]     pc;
        logic [REG_BITS-1:0] rd;
        logic [REG_BITS-1:0] rs1;
        logic [REG_BITS-1:0] rs2;
        logic [XLEN-1:0]     imm;
        logic [3:0]          alu_op;
        logic [3:0]          inst_type;
        logic [3:0]          mem_wbmask;
        logic                is_mem_sign;
        logic                is_ebreak;
        logic                is_illegal;
    } bundle_t;

    // A 5-bit register field is usable only if its bits above REG_BITS are clear.
    function automatic logic reg_ok(input logic [4:0] f);
        return (32'(f) >> REG_BITS) == 32'd0;
    endfunction

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  f_rd, f_rs1, f_rs2;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode = in_inst[6:0];
    assign funct3 = in_inst[14:12];
    assign funct7 = in_inst[31:25];
    assign f_rd   = in_inst[11:7];
    assign f_rs1  = in_inst[19:15];
    assign f_rs2  = in_inst[24:20];

    assign imm_i = {{20{in_inst[31]}}, in_inst[31:20]};
    assign imm_s = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
    assign imm_b = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
    assign imm_u = {in_inst[31:12], 12'h000};
    assign imm_j = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

    bundle_t     dec;
    logic        use_rd, use_rs1, use_rs2;
    logic        bad;
    logic        alt;
    logic [2:0]  op3;
    logic [3:0]  typ;
    logic [3:0]  mask;
    logic        sgn;
    logic        is_ebk;
    logic [31:0] imm32;

    always_comb begin
        dec     = '0;
        use_rd  = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        bad     = 1'b0;
        alt     = 1'b0;
        op3     = 3'b000;
        typ     = T_ILL;
        mask    = 4'b0000;
        sgn     = 1'b0;
        is_ebk  = 1'b0;
        imm32   = '0;

        case (opcode)
            7'b0010011: begin
                typ     = T_IMM;
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                imm32   = imm_i;
                op3     = funct3;
                alt     = (funct3 == 3'b101) && in_inst[30];
            end
            7'b0110011: begin
                typ     = T_REG;
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                op3     = funct3;
                alt     = in_inst[30];
                bad     = !((funct7 == 7'b0000000) ||
                            ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
            end
            7'b0000011: begin
                typ     = T_LOAD;
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                imm32   = imm_i;
                sgn     = funct3[2];
                bad     = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
            end
            7'b0100011: begin
                typ     = T_STORE;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                imm32   = imm_s;
                bad     = funct3 > 3'b010;
            end
            7'b0110111: begin
                typ    = T_LUI;
                use_rd = 1'b1;
                imm32  = imm_u;
            end
            7'b0010111: begin
                typ    = T_AUIPC;
                use_rd = 1'b1;
                imm32  = imm_u;
            end
            7'b1101111: begin
                typ    = T_JAL;
                use_rd = 1'b1;
                imm32  = imm_j;
            end
            7'b1100111: begin
                typ     = T_JALR;
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                imm32   = imm_i;
                bad     = funct3 != 3'b000;
            end
            7'b1100011: begin
                typ     = T_BRANCH;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                imm32   = imm_b;
                op3     = funct3;
                bad     = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            7'b1110011: begin
                typ    = T_SYS;
                is_ebk = in_inst == INST_EBREAK;
                bad    = (in_inst != INST_ECALL) && (in_inst != INST_EBREAK);
            end
            default: bad = 1'b1;
        endcase

        // Byte-enable mask follows access size; only meaningful for memory ops.
        if ((typ == T_LOAD) || (typ == T_STORE)) begin
            case (funct3[1:0])
                2'b00:   mask = 4'b0001;
                2'b01:   mask = 4'b0011;
                2'b10:   mask = 4'b1111;
                default: mask = 4'b0000;
            endcase
        end

        bad = bad || (use_rd && !reg_ok(f_rd)) || (use_rs1 && !reg_ok(f_rs1)) ||
              (use_rs2 && !reg_ok(f_rs2));

        dec.pc = in_pc;
        if (bad) begin
            dec.inst_type  = T_ILL;
            dec.is_illegal = 1'b1;
        end else begin
            dec.rd          = use_rd  ? REG_BITS'(f_rd)  : '0;
            dec.rs1         = use_rs1 ? REG_BITS'(f_rs1) : '0;
            dec.rs2         = use_rs2 ? REG_BITS'(f_rs2) : '0;
            dec.imm         = XLEN'($signed(imm32));
            dec.alu_op      = {alt, op3};
            dec.inst_type   = typ;
            dec.mem_wbmask  = mask;
            dec.is_mem_sign = sgn;
            dec.is_ebreak   = is_ebk;
        end
    end

    bundle_t out_q, out_d;
    bundle_t skid_q, skid_d;
    logic    out_valid_q, out_valid_d;
    logic    skid_valid_q, skid_valid_d;
    logic    halted_q, halted_d;
    logic    accept;

    assign in_ready = !skid_valid_q && !halted_q;
    assign accept   = in_valid && in_ready;

    always_comb begin
        out_d        = out_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        halted_d     = halted_q || (accept && dec.is_ebreak);

        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || out_ready) begin
            // Skid entry is older than anything arriving now, so it goes first.
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_d       = dec;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            halted_q     <= halted_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_pc      = out_q.pc;
    assign rd          = out_q.rd;
    assign rs1         = out_q.rs1;
    assign rs2         = out_q.rs2;
    assign imm         = out_q.imm;
    assign alu_op      = out_q.alu_op;
    assign inst_type   = out_q.inst_type;
    assign mem_wbmask  = out_q.mem_wbmask;
    assign is_mem_sign = out_q.is_mem_sign;
    assign ebreak      = out_q.is_ebreak;
    assign illegal     = out_q.is_illegal;
    assign halted      = halted_q;

endmodule

// File: tb/tb_dec_stage.sv
// Bench for dec_stage: directed spec examples plus random traffic against a 2-deep queue model
// and an arithmetic reference decoder.
module tb_dec_stage;

    localparam logic [31:0] ECALL  = 32'h0000_0073;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] in_inst, in_pc, out_pc, imm;
    logic [4:0]  rd, rs1, rs2;
    logic [3:0]  alu_op, inst_type, mem_wbmask;
    logic        is_mem_sign, ebreak, illegal, halted;

    always #5 clock = ~clock;

    dec_stage #(.XLEN(32), .REG_BITS(5)) dut (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_pc(out_pc), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .alu_op(alu_op), .inst_type(inst_type), .mem_wbmask(mem_wbmask),
        .is_mem_sign(is_mem_sign), .ebreak(ebreak), .illegal(illegal), .halted(halted)
    );

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
        logic [3:0]  alu, typ, mask;
        logic        sgn, ebk, ill;
    } exp_t;

    exp_t        mq[$];
    logic        m_halted;
    logic [31:0] obs[$];
    logic        last_acc;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
        exp_t        e;
        logic [6:0]  op, f7;
        logic [2:0]  f3;
        logic signed [31:0] sw;
        logic [31:0] ii, is_, ib, iu, ij;
        logic        ok, u_rd, u_rs1, u_rs2;
        e  = '{default: 0};
        op = w[6:0];
        f3 = w[14:12];
        f7 = w[31:25];
        sw = signed'(w);
        ii  = 32'(sw >>> 20);
        is_ = 32'((sw >>> 25) <<< 5) | 32'(w[11:7]);
        ib  = 32'((sw >>> 31) <<< 12) | (32'(w[7]) << 11) | (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
        iu  = w & 32'hFFFF_F000;
        ij  = 32'((sw >>> 31) <<< 20) | (32'(w[19:12]) << 12) | (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
        ok = 1'b1; u_rd = 1'b0; u_rs1 = 1'b0; u_rs2 = 1'b0;
        case (op)
            7'h13: begin e.typ = 4'd0; u_rd = 1; u_rs1 = 1; e.imm = ii; e.alu = {(f3 == 3'd5) && w[30], f3}; end
            7'h33: begin
                e.typ = 4'd1; u_rd = 1; u_rs1 = 1; u_rs2 = 1; e.alu = {w[30], f3};
                ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
            end
            7'h03: begin
                e.typ = 4'd2; u_rd = 1; u_rs1 = 1; e.imm = ii; e.sgn = f3[2];
                ok = !(f3 inside {3'd3, 3'd6, 3'd7});
                e.mask = 4'((1 << (1 << f3[1:0])) - 1);
            end
            7'h23: begin
                e.typ = 4'd3; u_rs1 = 1; u_rs2 = 1; e.imm = is_; ok = f3 <= 3'd2;
                e.mask = 4'((1 << (1 << f3[1:0])) - 1);
            end
            7'h37: begin e.typ = 4'd4; u_rd = 1; e.imm = iu; end
            7'h17: begin e.typ = 4'd5; u_rd = 1; e.imm = iu; end
            7'h6F: begin e.typ = 4'd6; u_rd = 1; e.imm = ij; end
            7'h67: begin e.typ = 4'd7; u_rd = 1; u_rs1 = 1; e.imm = ii; ok = f3 == 3'd0; end
            7'h63: begin
                e.typ = 4'd8; u_rs1 = 1; u_rs2 = 1; e.imm = ib; e.alu = {1'b0, f3};
                ok = !(f3 inside {3'd2, 3'd3});
            end
            7'h73: begin e.typ = 4'd9; ok = (w == ECALL) || (w == EBREAK); e.ebk = w == EBREAK; end
            default: ok = 1'b0;
        endcase
        e.rd  = u_rd  ? w[11:7]  : 5'd0;
        e.rs1 = u_rs1 ? w[19:15] : 5'd0;
        e.rs2 = u_rs2 ? w[24:20] : 5'd0;
        if (!ok) begin
            e     = '{default: 0};
            e.typ = 4'd15;
            e.ill = 1'b1;
        end
        e.pc = pc;
        return e;
    endfunction

    function automatic logic [31:0] gen_inst();
        logic [31:0] w;
        int          pick;
        w    = $urandom;
        pick = $urandom_range(0, 11);
        case (pick)
            0:  w[6:0] = 7'h13;
            1:  begin
                w[6:0] = 7'h33;
                case ($urandom_range(0, 2))
                    0:       w[31:25] = 7'h00;
                    1:       w[31:25] = 7'h20;
                    default: ;
                endcase
            end
            2:  w[6:0] = 7'h03;
            3:  w[6:0] = 7'h23;
            4:  w[6:0] = 7'h37;
            5:  w[6:0] = 7'h17;
            6:  w[6:0] = 7'h6F;
            7:  begin w[6:0] = 7'h67; if ($urandom_range(0, 3) != 0) w[14:12] = 3'd0; end
            8:  w[6:0] = 7'h63;
            9:  begin if ($urandom_range(0, 1) == 0) w = ECALL; else w[6:0] = 7'h73; end
            10: ;
            default: w = 32'h0;
        endcase
        if (w[6:0] == 7'h0F) w[6:0] = 7'h13;
        if (w == EBREAK) w = ECALL;
        return w;
    endfunction

    task automatic check_state();
        exp_t e;
        chk_eq("out_valid", 32'(out_valid), 32'(mq.size() > 0));
        chk_eq("in_ready", 32'(in_ready), 32'((mq.size() < 2) && !m_halted));
        chk_eq("halted", 32'(halted), 32'(m_halted));
        if (mq.size() > 0) begin
            e = mq[0];
            chk_eq("out_pc", out_pc, e.pc);
            chk_eq("rd", 32'(rd), 32'(e.rd));
            chk_eq("rs1", 32'(rs1), 32'(e.rs1));
            chk_eq("rs2", 32'(rs2), 32'(e.rs2));
            chk_eq("imm", imm, e.imm);
            chk_eq("alu_op", 32'(alu_op), 32'(e.alu));
            chk_eq("inst_type", 32'(inst_type), 32'(e.typ));
            chk_eq("mem_wbmask", 32'(mem_wbmask), 32'(e.mask));
            chk_eq("is_mem_sign", 32'(is_mem_sign), 32'(e.sgn));
            chk_eq("ebreak", 32'(ebreak), 32'(e.ebk));
            chk_eq("illegal", 32'(illegal), 32'(e.ill));
        end
    endtask

    // Starts and ends at a falling edge; drives one cycle and updates the queue model.
    task automatic cycle(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                         input logic ordy, input logic fl);
        logic acc, pop;
        in_valid  = v;
        in_inst   = inst;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
        acc = v && (mq.size() < 2) && !m_halted;
        pop = ordy && (mq.size() > 0);
        #1;
        if (out_valid && out_ready) obs.push_back(out_pc);
        @(posedge clock);
        if (fl) begin
            mq.delete();
        end else begin
            if (pop) void'(mq.pop_front());
            if (acc) mq.push_back(ref_decode(inst, pc));
        end
        if (acc && inst == EBREAK) m_halted = 1'b1;
        last_acc = acc;
        @(negedge clock);
        check_state();
    endtask

    task automatic do_reset();
        #2 reset_n = 1'b0;
        #1;
        chk_eq("rst_out_valid", 32'(out_valid), 32'd0);
        chk_eq("rst_halted", 32'(halted), 32'd0);
        mq.delete();
        m_halted = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        check_state();
    endtask

    logic [31:0] s_inst[4];
    logic [31:0] s_pc[4];
    logic [31:0] pc_r;
    int          idx;

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b0;
        m_halted = 1'b0; last_acc = 1'b0;
        #2;
        chk_eq("reset_out_valid", 32'(out_valid), 32'd0);
        chk_eq("reset_halted", 32'(halted), 32'd0);
        chk_eq("reset_imm", imm, 32'd0);
        chk_eq("reset_rd", 32'(rd), 32'd0);
        chk_eq("reset_type", 32'(inst_type), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        check_state();

        cycle(1, 32'h0050_0093, 32'h100, 1, 0);
        chk_eq("t1_valid", 32'(out_valid), 32'd1);
        chk_eq("t1_rd", 32'(rd), 32'd1);
        chk_eq("t1_rs1", 32'(rs1), 32'd0);
        chk_eq("t1_imm", imm, 32'd5);
        chk_eq("t1_type", 32'(inst_type), 32'd0);
        chk_eq("t1_alu", 32'(alu_op), 32'd0);
        cycle(1, 32'h4000_0093, 32'h104, 1, 0);
        chk_eq("t2_addi_alu", 32'(alu_op), 32'h0);
        cycle(1, 32'h4030_D113, 32'h108, 1, 0);
        chk_eq("t2_srai_alu", 32'(alu_op), 32'hD);
        cycle(1, 32'h4020_81B3, 32'h10C, 1, 0);
        chk_eq("t2_sub_type", 32'(inst_type), 32'd1);
        chk_eq("t2_sub_alu", 32'(alu_op), 32'h8);
        cycle(1, 32'h0011_2223, 32'h110, 1, 0);
        chk_eq("t3_sw_type", 32'(inst_type), 32'd3);
        chk_eq("t3_sw_rs1", 32'(rs1), 32'd2);
        chk_eq("t3_sw_rs2", 32'(rs2), 32'd1);
        chk_eq("t3_sw_imm", imm, 32'd4);
        chk_eq("t3_sw_mask", 32'(mem_wbmask), 32'hF);
        cycle(1, 32'h0000_C083, 32'h114, 1, 0);
        chk_eq("t3_lbu_type", 32'(inst_type), 32'd2);
        chk_eq("t3_lbu_mask", 32'(mem_wbmask), 32'h1);
        chk_eq("t3_lbu_sign", 32'(is_mem_sign), 32'd1);
        cycle(1, 32'hFE00_0EE3, 32'h118, 1, 0);
        chk_eq("t3_beq_type", 32'(inst_type), 32'd8);
        chk_eq("t3_beq_imm", imm, 32'hFFFF_FFFC);
        cycle(1, 32'h0080_00EF, 32'h11C, 1, 0);
        chk_eq("t3_jal_type", 32'(inst_type), 32'd6);
        chk_eq("t3_jal_imm", imm, 32'd8);
        cycle(1, 32'h0000_0000, 32'h120, 1, 0);
        chk_eq("t6_zero_ill", 32'(illegal), 32'd1);
        chk_eq("t6_zero_type", 32'(inst_type), 32'd15);
        cycle(1, 32'h0000_B083, 32'h124, 1, 0);
        chk_eq("t6_ld011_ill", 32'(illegal), 32'd1);
        chk_eq("t6_ld011_type", 32'(inst_type), 32'd15);
        cycle(0, 32'h0, 32'h0, 1, 0);

        // Four-instruction stream with three stalled cycles up front.
        for (int i = 0; i < 4; i++) begin
            s_inst[i] = gen_inst();
            s_pc[i]   = 32'h2000 + 32'(i * 4);
        end
        obs.delete();
        idx = 0;
        for (int c = 0; c < 30 && obs.size() < 4; c++) begin
            cycle(idx < 4, (idx < 4) ? s_inst[idx] : 32'h0, (idx < 4) ? s_pc[idx] : 32'h0, c >= 3, 0);
            if (last_acc) idx++;
            if (c == 2) begin
                chk_eq("t4_stall_in_ready", 32'(in_ready), 32'd0);
                chk_eq("t4_stall_valid", 32'(out_valid), 32'd1);
                chk_eq("t4_stall_head", out_pc, s_pc[0]);
            end
        end
        chk_eq("t4_delivered", 32'(obs.size()), 32'd4);
        for (int i = 0; i < 4 && i < obs.size(); i++) chk_eq("t4_order", obs[i], s_pc[i]);
        cycle(0, 32'h0, 32'h0, 1, 0);

        cycle(1, gen_inst(), 32'h3000, 0, 0);
        cycle(1, gen_inst(), 32'h3004, 0, 0);
        cycle(0, 32'h0, 32'h0, 0, 1);
        chk_eq("flush_valid", 32'(out_valid), 32'd0);
        chk_eq("flush_in_ready", 32'(in_ready), 32'd1);

        cycle(1, gen_inst(), 32'h3100, 0, 0);
        cycle(1, gen_inst(), 32'h3104, 0, 0);
        do_reset();

        pc_r = 32'h4000;
        for (int c = 0; c < 600; c++) begin
            cycle($urandom_range(0, 3) != 0, gen_inst(), pc_r, $urandom_range(0, 9) < 7,
                  $urandom_range(0, 19) == 0);
            if (last_acc) pc_r = pc_r + 32'd4;
        end
        cycle(0, 32'h0, 32'h0, 1, 0);
        cycle(0, 32'h0, 32'h0, 1, 0);

        cycle(1, ECALL, 32'h5000, 1, 0);
        chk_eq("ecall_type", 32'(inst_type), 32'd9);
        chk_eq("ecall_ebreak", 32'(ebreak), 32'd0);
        chk_eq("ecall_halted", 32'(halted), 32'd0);
        cycle(1, EBREAK, 32'h5004, 1, 0);
        chk_eq("ebreak_flag", 32'(ebreak), 32'd1);
        chk_eq("ebreak_type", 32'(inst_type), 32'd9);
        chk_eq("ebreak_halted", 32'(halted), 32'd1);
        chk_eq("ebreak_in_ready", 32'(in_ready), 32'd0);
        for (int c = 0; c < 3; c++) begin
            cycle(1, 32'h0050_0093, 32'h5008, 1, 0);
            chk_eq("halt_in_ready", 32'(in_ready), 32'd0);
        end
        do_reset();
        chk_eq("post_rst_halted", 32'(halted), 32'd0);
        cycle(1, 32'h0050_0093, 32'h6000, 1, 0);
        chk_eq("post_rst_valid", 32'(out_valid), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
